// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the memory-access stage.
//   - funct3 encodings for loads and stores
//   - FSM state encoding for mem_stage
//   - default bus timeout (REQ cycles without ack)
package mem_pkg;

    localparam int DEFAULT_TIMEOUT = 16;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane logic for the memory stage.
//   funct3_i     : access size / sign
//   off_i        : byte offset within the word (addr[1:0])
//   is_store_i   : 1 = store, 0 = load
//   store_data_i : raw store data from the register file
//   rdata_i      : read word from the data bus
//   wstrb_o      : byte-lane enables (0 for loads)
//   wdata_o      : lane-replicated store data (0 for loads)
//   load_data_o  : selected and extended load result
//   misalign_o   : misaligned access or illegal funct3
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic        is_store_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    logic [4:0]  bit_off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        bit_off  = {off_i, 3'b000};
        byte_sel = rdata_i[bit_off +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        load_data_o = 32'h0;
        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data_o = {24'h0, byte_sel};
            F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data_o = {16'h0, half_sel};
            F3_LW:   load_data_o = rdata_i;
            default: load_data_o = 32'h0;
        endcase

        wstrb_o = 4'b0000;
        wdata_o = 32'h0;
        if (is_store_i) begin
            case (funct3_i)
                F3_SB: begin
                    wstrb_o = 4'b0001 << off_i;
                    wdata_o = {4{store_data_i[7:0]}};
                end
                F3_SH: begin
                    wstrb_o = off_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{store_data_i[15:0]}};
                end
                F3_SW: begin
                    wstrb_o = 4'b1111;
                    wdata_o = store_data_i;
                end
                default: ;
            endcase
        end

        // Unsigned byte/half encodings exist only for loads, so funct3[2]
        // makes them illegal on a store; 011/11x are illegal for both.
        case (funct3_i)
            3'b000, 3'b100: misalign_o = is_store_i && funct3_i[2];
            3'b001, 3'b101: misalign_o = off_i[0] || (is_store_i && funct3_i[2]);
            3'b010:         misalign_o = (off_i != 2'b00);
            default:        misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage (EX/MEM -> MEM/WB).
//   Issues loads/stores over a req/ack data bus, with a timeout that turns
//   a hung access into a bus error. Registers the write-back result and
//   raises stall_O while an access is outstanding so EX/MEM stays frozen.
//   Inputs  : EX/MEM fields (*_MEM_I), dmem_ack_I / dmem_rdata_I.
//   Outputs : dmem_* bus request, stall_O, MEM/WB fields (wb_*, *_WB_O),
//             misalign_O / bus_err_O fault flags (valid with wb_valid_O).
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_MEM_I,
    input  logic [31:0] ALU_result_MEM_I,
    input  logic [31:0] Rd_data2_MEM_I,
    input  logic [31:0] pc_order_MEM_I,
    input  logic [2:0]  funct3_MEM_I,
    input  logic        mem_read_MEM_I,
    input  logic        mem_write_MEM_I,
    input  logic [4:0]  rd_addr_MEM_I,
    input  logic        reg_write_MEM_I,
    output logic        dmem_req_O,
    output logic        dmem_we_O,
    output logic [31:0] dmem_addr_O,
    output logic [3:0]  dmem_wstrb_O,
    output logic [31:0] dmem_wdata_O,
    input  logic        dmem_ack_I,
    input  logic [31:0] dmem_rdata_I,
    output logic        stall_O,
    output logic        wb_valid_O,
    output logic [31:0] wb_data_O,
    output logic [4:0]  rd_addr_WB_O,
    output logic        reg_write_WB_O,
    output logic [31:0] pc_order_WB_O,
    output logic        misalign_O,
    output logic        bus_err_O
);

    localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        reg_write_q, reg_write_d;
    logic [31:0] pc_order_q, pc_order_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
    logic        stall;

    logic        is_mem;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misalign;

    assign is_mem = mem_read_MEM_I || mem_write_MEM_I;

    // EX/MEM is frozen by stall_O, so the align unit can look at the live
    // inputs in every state, including REQ when the read data comes back.
    mem_align u_align (
        .funct3_i     (funct3_MEM_I),
        .off_i        (ALU_result_MEM_I[1:0]),
        .is_store_i   (mem_write_MEM_I),
        .store_data_i (Rd_data2_MEM_I),
        .rdata_i      (dmem_rdata_I),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load),
        .misalign_o   (al_misalign)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        wb_data_d   = wb_data_q;
        rd_addr_d   = rd_addr_q;
        pc_order_d  = pc_order_q;
        wb_valid_d  = 1'b0;
        reg_write_d = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        stall       = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 5'd0;
                if (valid_MEM_I) begin
                    rd_addr_d  = rd_addr_MEM_I;
                    pc_order_d = pc_order_MEM_I;
                    if (!is_mem) begin
                        wb_valid_d  = 1'b1;
                        wb_data_d   = ALU_result_MEM_I;
                        reg_write_d = reg_write_MEM_I;
                    end else begin
                        stall = 1'b1;
                        if (al_misalign) begin
                            state_d    = S_DONE;
                            wb_valid_d = 1'b1;
                            misalign_d = 1'b1;
                            wb_data_d  = 32'h0;
                        end else begin
                            state_d = S_REQ;
                            addr_d  = {ALU_result_MEM_I[31:2], 2'b00};
                            we_d    = mem_write_MEM_I;
                            wstrb_d = al_wstrb;
                            wdata_d = al_wdata;
                        end
                    end
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (dmem_ack_I) begin
                    state_d     = S_DONE;
                    wb_valid_d  = 1'b1;
                    reg_write_d = reg_write_MEM_I;
                    wb_data_d   = mem_write_MEM_I ? ALU_result_MEM_I : al_load;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = S_DONE;
                    wb_valid_d = 1'b1;
                    bus_err_d  = 1'b1;
                    wb_data_d  = 32'h0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            addr_q      <= 32'h0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'h0;
            wdata_q     <= 32'h0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= 32'h0;
            rd_addr_q   <= 5'd0;
            reg_write_q <= 1'b0;
            pc_order_q  <= 32'h0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
            pc_order_q  <= pc_order_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // stall is combinational from IDLE inputs, so gate it with reset to make
    // it drop immediately even while EX/MEM still presents a memory op.
    assign stall_O        = stall && rst_n;
    assign dmem_req_O     = (state_q == S_REQ);
    assign dmem_we_O      = we_q;
    assign dmem_addr_O    = addr_q;
    assign dmem_wstrb_O   = wstrb_q;
    assign dmem_wdata_O   = wdata_q;
    assign wb_valid_O     = wb_valid_q;
    assign wb_data_O      = wb_data_q;
    assign rd_addr_WB_O   = rd_addr_q;
    assign reg_write_WB_O = reg_write_q;
    assign pc_order_WB_O  = pc_order_q;
    assign misalign_O     = misalign_q;
    assign bus_err_O      = bus_err_q;

endmodule
